// File: rtl/sys_defs.sv
// ============================================================================
// Module : sys_defs
// Shared machine-width constants and types for rename/retire.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sys_defs;

  localparam int N                = 3;
  localparam int PHYS_REG_SZ_R10K = 64;
  localparam int PHYS_TAG_W       = (PHYS_REG_SZ_R10K > 1) ? $clog2(PHYS_REG_SZ_R10K) : 1;

  typedef logic [PHYS_TAG_W-1:0]       PHYS_TAG;
  typedef logic [PHYS_REG_SZ_R10K-1:0] FREE_MASK;

endpackage

`default_nettype wire

// File: rtl/free_list_picker.sv
// ============================================================================
// Module : free_list_picker
// Combinational multi-grant selector: lowest set bits go to the highest lanes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module free_list_picker
  import sys_defs::*;
#(
  parameter int N_LANES   = N,
  parameter int PHYS_REGS = PHYS_REG_SZ_R10K
) (
  input  logic [PHYS_REGS-1:0]        i_bitmap,
  output PHYS_TAG [N_LANES-1:0]       o_tags,
  output logic [N_LANES-1:0]          o_valids
);

  logic [PHYS_REGS-1:0] w_rem;
  logic                 w_found;
  PHYS_TAG              w_idx;

  // Each pass takes the lowest remaining bit and removes it for the next lane.
  always_comb begin
    w_rem    = i_bitmap;
    o_tags   = '0;
    o_valids = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N_LANES; k++) begin
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = PHYS_REGS - 1; i >= 0; i--) begin
        if (w_rem[i]) begin
          w_found = 1'b1;
          w_idx   = PHYS_TAG'(i);
        end
      end
      if (w_found) begin
        o_tags[N_LANES-1-k]   = w_idx;
        o_valids[N_LANES-1-k] = 1'b1;
        w_rem[w_idx]          = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/free_list.sv
// ============================================================================
// Module : free_list
// R10K physical-register free list with speculative and retirement views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module free_list
  import sys_defs::*;
#(
  parameter int N_LANES    = N,
  parameter int ARCH_COUNT = 32,
  parameter int PHYS_REGS  = PHYS_REG_SZ_R10K,
  localparam int PRW       = (PHYS_REGS > 1) ? $clog2(PHYS_REGS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_LANES-1:0]     alloc_en,
  output PHYS_TAG [N_LANES-1:0]  alloc_tags,
  output logic [N_LANES-1:0]     alloc_valids,
  output logic [PRW:0]           free_count,
  input  logic [PHYS_REGS-1:0]   free_mask,
  input  logic [N_LANES-1:0]     retire_write_enables,
  input  PHYS_TAG [N_LANES-1:0]  retire_phys_regs,
  input  logic                   bp_recover_en
);

  localparam logic [PHYS_REGS-1:0] c_arch_reset =
    {{(PHYS_REGS-ARCH_COUNT){1'b0}}, {ARCH_COUNT{1'b1}}};
  localparam logic [PHYS_REGS-1:0] c_no_pr0 = {{(PHYS_REGS-1){1'b1}}, 1'b0};

  logic [PHYS_REGS-1:0] r_spec_free;
  logic [PHYS_REGS-1:0] r_arch_used;
  logic [PHYS_REGS-1:0] w_free_eff;
  logic [PHYS_REGS-1:0] w_granted;
  logic [PHYS_REGS-1:0] w_retire_set;
  logic [PHYS_REGS-1:0] w_arch_next;
  logic [PHYS_REGS-1:0] w_spec_next;
  logic [N_LANES-1:0]   w_pick_valids;

  free_list_picker #(
    .N_LANES   (N_LANES),
    .PHYS_REGS (PHYS_REGS)
  ) u_picker (
    .i_bitmap (r_spec_free),
    .o_tags   (alloc_tags),
    .o_valids (w_pick_valids)
  );

  assign alloc_valids = w_pick_valids & ~{N_LANES{bp_recover_en}};
  assign w_free_eff   = free_mask & c_no_pr0;

  always_comb begin
    w_granted    = '0;
    w_retire_set = '0;
    for (int w = 0; w < N_LANES; w++) begin
      if (alloc_en[w] && alloc_valids[w])
        w_granted[alloc_tags[w]] = 1'b1;
      if (retire_write_enables[w] && (retire_phys_regs[w] != '0))
        w_retire_set[retire_phys_regs[w]] = 1'b1;
    end
  end

  // Recovery rebuilds from the already-updated retirement view.
  assign w_arch_next = (r_arch_used & ~w_free_eff) | w_retire_set;
  assign w_spec_next = bp_recover_en ? (~w_arch_next & c_no_pr0)
                                     : (((r_spec_free & ~w_granted) | w_free_eff) & c_no_pr0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_arch_used <= c_arch_reset;
      r_spec_free <= ~c_arch_reset & c_no_pr0;
    end else begin
      r_arch_used <= w_arch_next;
      r_spec_free <= w_spec_next;
    end
  end

  always_comb begin
    free_count = '0;
    for (int i = 0; i < PHYS_REGS; i++)
      free_count = free_count + (PRW+1)'(r_spec_free[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      assert ((r_spec_free & r_arch_used) == '0);
      assert ((w_free_eff & r_spec_free) == '0);
      if (!bp_recover_en)
        assert ((alloc_en & ~w_pick_valids) == '0);
    end
  end

endmodule

`default_nettype wire

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the R10K rename scheme.
- Hands up to N free physical tags per cycle to dispatch/rename.
- Consumes the retire stage's per-cycle free bitmap (committed lanes' Told) and arch-map write lanes.
- Keeps a speculative free bitmap and a retirement-view bitmap; rebuilds the speculative view in one cycle on the branch-recovery pulse.

Parameters:
- N, `N, superscalar width (alloc and retire lanes).
- ARCH_COUNT, 32, architectural registers.
- PHYS_REGS, `PHYS_REG_SZ_R10K, physical registers.
- PRW, derived localparam, clog2(PHYS_REGS), minimum 1.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low: state resets on any rising edge with reset==0.
- alloc_en  in  N  lane w consumes alloc_tags[w] this cycle.
- alloc_tags  out  N x PHYS_TAG  lowest free tags; lane N-1 = lowest index.
- alloc_valids  out  N  alloc_tags[w] names a genuinely free PR.
- free_count  out  PRW+1  popcount of the speculative free bitmap.
- free_mask  in  PHYS_REGS  PRs released by retire this cycle.
- retire_write_enables  in  N  arch-map commit lanes from retire.
- retire_phys_regs  in  N x PHYS_TAG  PRs becoming architecturally mapped.
- bp_recover_en  in  1  one-cycle recovery pulse.

Behaviour:
State:
- spec_free[PHYS_REGS]: speculative free bitmap.
- arch_used[PHYS_REGS]: PRs held by the committed map.

Reset (reset==0 at edge):
- arch_used[0..ARCH_COUNT-1]=1, rest 0.
- spec_free = ~arch_used.
- Outputs after reset: free_count = PHYS_REGS-ARCH_COUNT; alloc_tags = ARCH_COUNT+N-1-w for lane w; alloc_valids all 1 when enough PRs are free.
- Reset has priority over every other input, mid-operation included.

PR 0 handling:
- PR 0 is never free and never allocated.
- free_mask[0] is ignored; retire_phys_regs==0 is ignored.

Allocation (combinational tags, registered consume):
- Picker scans spec_free from index 0 upward.
- First free PR goes to lane N-1, second to lane N-2, and so on.
- Lanes with no free PR: alloc_valids=0, alloc_tags=0.
- Dispatch must not assert alloc_en[w] with alloc_valids[w]==0. Such lanes are ignored and flagged by an assertion.
- alloc_en need not be contiguous. Each granted lane clears its spec_free bit at the edge.
- Granted tags never repeat until freed again.

Release:
- At the edge, spec_free |= free_mask and arch_used &= ~free_mask.
- For each enabled retire lane, arch_used[retire_phys_regs[w]] = 1.
- A freed PR is not visible on alloc_tags until the following cycle (no same-cycle bypass).

Same-cycle update order:
- arch_used' = (arch_used & ~free_mask) | retire_set.
- spec_free' = (spec_free & ~granted) | free_mask.

Recovery (bp_recover_en=1):
- spec_free' = ~arch_used' with bit 0 forced to 0, using the same-cycle-updated arch_used'.
- alloc_valids are forced to 0 during the recovery cycle, and alloc_en is ignored.
- Retire never commits on the recovery cycle, but the rule above still defines the result if it did.

free_count:
- Combinational popcount of the registered spec_free.

Invariants (asserted):
- spec_free & arch_used is never set at a stable point.
- free_mask never frees a PR already in spec_free.

Decomposition:
- Shared package (sys_defs): PHYS_TAG, PHYS_REG_SZ_R10K, N, plus a FREE_MASK typedef (logic [PHYS_REGS-1:0]) so stage_retire and free_list share one type.
- One sub-module, free_list_picker: combinational multi-grant lowest-first selector.
  - Input: bitmap.
  - Outputs: N tags plus N valids.
  - Reusable for RS/ROB slot allocation.

Test Plan (N=3, PHYS_REGS=64, ARCH_COUNT=32):
- Reset: hold reset=0 for 2 cycles, release -> free_count=32, alloc_tags={32,33,34} (lanes 2,1,0), alloc_valids=3'b111.
- Allocation: alloc_en=3'b111, then 3'b101 -> tags {35,36,37}, then free_count=27 with next tags {36,38,39}.
- Release: allocate down to 0 free (alloc_valids=0, tags 0); pulse free_mask bit 40 -> same cycle alloc_valids=0; next cycle lane 2 = 40, valid=1, free_count=1.
- Retire view: retire_write_enables lane 2 with phys 33 plus free_mask bit 5 -> arch_used[33]=1, arch_used[5]=0, spec_free[5]=1.
- Recovery: after allocating 32..40 with only 33 retired, pulse bp_recover_en -> next cycle spec_free = ~arch_used: 32 and 34..40 free again, 33 not free, 5 free; recovery-cycle alloc_valids=0.
- Edge cases:
  - free_mask bit 0 set -> PR 0 never appears on alloc_tags.
  - reset=0 asserted mid-allocation -> next cycle matches the post-reset values.
  - free_mask in the same cycle as alloc_en of a different tag -> both effects applied.
